lfsr_bist_ctrl: RTL and testbench

LFSR_BIST_CTRL -- requirements
Module: lfsr_bist_ctrl

---
 rtl/lfsr_bist_ctrl.sv | 109 ++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_bist_ctrl.sv
// lfsr_bist_ctrl: BIST sequencer that seeds an external 7-bit LFSR, steps it
// N_PATTERNS times while compacting the CUT response into a 7-bit MISR, then
// latches the signature and a pass flag against GOLDEN_SIG.
// Optional feature: define BIST_ABORT_EN to add an abort input that ends a run
// early from SEED or RUN (forced fail, signature = MISR at abort time).
module lfsr_bist_ctrl #(
  parameter int         N_PATTERNS = 127,
  parameter logic [6:0] GOLDEN_SIG = 7'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef BIST_ABORT_EN
  input  logic       abort,
`endif
  input  logic [6:0] resp,
  output logic       lfsr_rst,
  output logic       lfsr_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_COMP,
    S_DONE
  } state_t;

  // Counter value on the final RUN cycle; counter never needs to exceed it.
  localparam logic [6:0] LAST_CNT = 7'(N_PATTERNS - 1);

  state_t     state_q, state_d;
  logic [6:0] misr_q, misr_d;
  logic [6:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic [6:0] sig_q, sig_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      misr_q  <= 7'h00;
      cnt_q   <= 7'h00;
      pass_q  <= 1'b0;
      sig_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  // Next-state, MISR compaction, pattern count and result capture.
  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SEED;
      end
      S_SEED: begin
        misr_d  = 7'h00;
        cnt_d   = 7'h00;
        state_d = S_RUN;
      end
      S_RUN: begin
        misr_d = {misr_q[5:0], misr_q[6] ^ misr_q[5]} ^ resp;
        // Hold the counter on the last pattern so it can never wrap.
        if (cnt_q == LAST_CNT) state_d = S_COMP;
        else                   cnt_d   = cnt_q + 7'd1;
      end
      S_COMP: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BIST_ABORT_EN
    // Abort overrides the normal flow only while a run is being set up or applied.
    if (abort && (state_q == S_SEED || state_q == S_RUN)) begin
      state_d = S_DONE;
      pass_d  = 1'b0;
      sig_d   = misr_q;
    end
`endif
  end

  // Control outputs are pure state decodes.
  assign lfsr_rst  = (state_q == S_SEED);
  assign lfsr_en   = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl. Four instances cover the default
// configuration and short-run configurations. Cycle k is the clock period
// after rising edge k (edge 0 samples start); outputs are sampled on negedges.
module tb_lfsr_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [6:0] resp0 = 7'h00, resp1 = 7'h00;
`ifdef BIST_ABORT_EN
  logic       abort0 = 1'b0;
  logic       abort_off = 1'b0;
`endif

  logic       lr0, le0, bz0, dn0, ps0;
  logic [6:0] sg0;
  logic       lr1, le1, bz1, dn1, ps1;
  logic [6:0] sg1;
  logic       lr2, le2, bz2, dn2, ps2;
  logic [6:0] sg2;
  logic       lr3, le3, bz3, dn3, ps3;
  logic [6:0] sg3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_bist_ctrl u_def (
    .clk(clk), .reset(reset), .start(start0),
`ifdef BIST_ABORT_EN
    .abort(abort0),
`endif
    .resp(resp0), .lfsr_rst(lr0), .lfsr_en(le0), .busy(bz0), .done(dn0),
    .pass(ps0), .signature(sg0));

  lfsr_bist_ctrl #(.N_PATTERNS(2), .GOLDEN_SIG(7'h00)) u_n2g0 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .resp(resp1), .lfsr_rst(lr1), .lfsr_en(le1), .busy(bz1), .done(dn1),
    .pass(ps1), .signature(sg1));

  lfsr_bist_ctrl #(.N_PATTERNS(2), .GOLDEN_SIG(7'h03)) u_n2g3 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .resp(resp1), .lfsr_rst(lr2), .lfsr_en(le2), .busy(bz2), .done(dn2),
    .pass(ps2), .signature(sg2));

  lfsr_bist_ctrl #(.N_PATTERNS(1)) u_n1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .resp(resp1), .lfsr_rst(lr3), .lfsr_en(le3), .busy(bz3), .done(dn3),
    .pass(ps3), .signature(sg3));

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    tests++; if ({lr0, le0, bz0, dn0} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got rst/en/busy/done=%b exp 0000", {lr0, le0, bz0, dn0});
    end
    tests++; if (ps0 !== 1'b0 || sg0 !== 7'h00) begin
      fails++; $display("FAIL reset_result got pass=%b sig=%h exp pass=0 sig=00", ps0, sg0);
    end
    tests++; if ({lr3, le3, bz3, dn3, ps3} !== 5'b00000 || sg3 !== 7'h00) begin
      fails++; $display("FAIL reset_n1 got ctrl=%b sig=%h exp 00000 sig=00", {lr3, le3, bz3, dn3, ps3}, sg3);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Full default run with stray start pulses during RUN and in DONE.
  task automatic test_default_run();
    int rst_cnt = 0, en_cnt = 0, first_en = -1, last_en = -1;
    int done_cyc = -1, done_cnt = 0, bad_busy = 0;
    resp0 = 7'h00;
    start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 132; k++) begin
      @(negedge clk);
      if (lr0) rst_cnt++;
      if (le0) begin en_cnt++; if (first_en < 0) first_en = k; last_en = k; end
      if (dn0) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      if (bz0 !== (k <= 130)) bad_busy++;
      start0 = (k == 5 || k == 50 || k == 130);
    end
    start0 = 1'b0;
    tests++; if (rst_cnt != 1) begin
      fails++; $display("FAIL def_lfsr_rst_count got %0d exp 1", rst_cnt);
    end
    tests++; if (en_cnt != 127 || first_en != 2 || last_en != 128) begin
      fails++; $display("FAIL def_lfsr_en got count=%0d first=%0d last=%0d exp 127/2/128", en_cnt, first_en, last_en);
    end
    tests++; if (done_cyc != 130 || done_cnt != 1) begin
      fails++; $display("FAIL def_done got cycle=%0d count=%0d exp 130/1", done_cyc, done_cnt);
    end
    tests++; if (bad_busy != 0) begin
      fails++; $display("FAIL def_busy got %0d bad cycles exp 0", bad_busy);
    end
    tests++; if (sg0 !== 7'h00 || ps0 !== 1'b1) begin
      fails++; $display("FAIL def_result got sig=%h pass=%b exp 00/1", sg0, ps0);
    end
  endtask

  task automatic test_short_runs();
    int rst3 = 0, en3 = 0, done3 = -1, done1 = -1;
    resp1 = 7'h01;
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (lr3) rst3++;
      if (le3) en3++;
      if (dn3 && done3 < 0) done3 = k;
      if (dn1 && done1 < 0) done1 = k;
      start1 = 1'b0;
    end
    tests++; if (sg1 !== 7'h03 || ps1 !== 1'b0) begin
      fails++; $display("FAIL n2_g0 got sig=%h pass=%b exp 03/0", sg1, ps1);
    end
    tests++; if (sg2 !== 7'h03 || ps2 !== 1'b1) begin
      fails++; $display("FAIL n2_g3 got sig=%h pass=%b exp 03/1", sg2, ps2);
    end
    tests++; if (sg3 !== 7'h01 || rst3 != 1 || en3 != 1) begin
      fails++; $display("FAIL n1_run got sig=%h rst=%0d en=%0d exp 01/1/1", sg3, rst3, en3);
    end
    tests++; if (done3 != 4 || done1 != 5) begin
      fails++; $display("FAIL short_done got n1=%0d n2=%0d exp 4/5", done3, done1);
    end
  endtask

  // resp is only 05 in cycle 2; everywhere else it is 7F.
  task automatic test_resp_outside_run();
    resp1 = 7'h7F;
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      resp1 = (k == 2) ? 7'h05 : 7'h7F;
    end
    tests++; if (sg3 !== 7'h05) begin
      fails++; $display("FAIL resp_n1 got sig=%h exp 05", sg3);
    end
    tests++; if (sg1 !== 7'h75) begin
      fails++; $display("FAIL resp_n2 got sig=%h exp 75", sg1);
    end
    resp1 = 7'h00;
  endtask

  // start held high on the N=1 instance: done at 4 and 9, idle at 5 and 10.
  task automatic test_back_to_back();
    int bad = 0;
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dn3 !== (k == 4 || k == 9)) bad++;
      if (bz3 !== !(k == 5 || k == 10)) bad++;
    end
    start1 = 1'b0;
    tests++; if (bad != 0) begin
      fails++; $display("FAIL back_to_back got %0d bad samples exp 0", bad);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int stray = 0, done_cyc = -1;
    start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bz0 !== 1'b0 || le0 !== 1'b0 || ps0 !== 1'b0 || sg0 !== 7'h00) begin
      fails++; $display("FAIL midrun_reset got busy=%b en=%b pass=%b sig=%h exp 0/0/0/00", bz0, le0, ps0, sg0);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dn0 || bz0 || le0) stray++;
    end
    tests++; if (stray != 0) begin
      fails++; $display("FAIL midrun_quiet got %0d active cycles exp 0", stray);
    end
    start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 131; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (dn0 && done_cyc < 0) done_cyc = k;
    end
    tests++; if (done_cyc != 130 || sg0 !== 7'h00 || ps0 !== 1'b1) begin
      fails++; $display("FAIL rerun got done=%0d sig=%h pass=%b exp 130/00/1", done_cyc, sg0, ps0);
    end
  endtask

`ifdef BIST_ABORT_EN
  // Abort in RUN cycle 5 (cycle 6) with resp=01: MISR then holds 0F.
  task automatic test_abort();
    int en_cnt = 0, done_cyc = -1, done_cnt = 0, late_en = 0;
    resp0 = 7'h01;
    start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (le0) begin en_cnt++; if (k > 6) late_en++; end
      if (dn0) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      abort0 = (k == 6);
    end
    abort0 = 1'b0;
    resp0 = 7'h00;
    tests++; if (done_cyc != 7 || done_cnt != 1) begin
      fails++; $display("FAIL abort_done got cycle=%0d count=%0d exp 7/1", done_cyc, done_cnt);
    end
    tests++; if (en_cnt != 5 || late_en != 0) begin
      fails++; $display("FAIL abort_en got count=%0d late=%0d exp 5/0", en_cnt, late_en);
    end
    tests++; if (ps0 !== 1'b0 || sg0 !== 7'h0F || bz0 !== 1'b0) begin
      fails++; $display("FAIL abort_result got pass=%b sig=%h busy=%b exp 0/0f/0", ps0, sg0, bz0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_short_runs();
    test_resp_outside_run();
    test_back_to_back();
    test_reset_mid_run();
`ifdef BIST_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
